// File: rtl/mod_counter_arbiter.sv
// mod_counter_arbiter
//   Shares one programmable modulo-N counter among NREQ requesters. A
//   round-robin arbiter picks a requester in IDLE and latches its modulus.
//   The counter then sweeps 0..mod-1 once, pulses done to the winner and
//   releases the grant.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   CW    counter / modulus width
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   hold       (only with MOD_ARB_HOLD_EN) freezes the sweep while in RUN
//   req        level request per requester
//   req_mod    modulus per requester, slice i = [i*CW +: CW]
//   grant      one-hot grant, visible for the RUN phase only
//   count      shared counter value
//   busy       high in LOAD and RUN
//   wrap       high in the RUN cycle where count == mod-1 (not while held)
//   done       one-cycle one-hot pulse to the requester that finished
//   abort      one-cycle pulse after the granted request dropped
//   state_dbg  current FSM state (IDLE=0, LOAD=1, RUN=2, DONE=3)
//
// Configuration
//   MOD_ARB_HOLD_EN  defined: adds the hold input. Undefined: RUN always
//                    advances every cycle.
//
// Handshake: req[i] is a level-sensitive valid that must stay high until
// done[i] or abort pulses; grant[i] is the ready/ownership indication. Dropping
// req[i] while granted (LOAD or RUN) ends the sweep with abort instead of done.
module mod_counter_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef MOD_ARB_HOLD_EN
    input  logic                 hold,
`endif
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   req_mod,
    output logic [NREQ-1:0]      grant,
    output logic [CW-1:0]        count,
    output logic                 busy,
    output logic                 wrap,
    output logic [NREQ-1:0]      done,
    output logic                 abort,
    output logic [1:0]           state_dbg
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;       // round-robin starting point
    logic [PW-1:0]   win;       // index of the current owner
    logic [CW-1:0]   last_q;    // final count of the sweep (mod-1, min 0)

    logic            hold_eff;
    logic            found;
    logic [PW-1:0]   pick;
    logic [CW-1:0]   pick_mod;
    logic [CW-1:0]   pick_last;
    logic [PW-1:0]   next_ptr;
    logic [NREQ-1:0] win_onehot;

`ifdef MOD_ARB_HOLD_EN
    assign hold_eff = hold;
`else
    assign hold_eff = 1'b0;
`endif

    // Scan from ptr upward with wraparound. Walking the offsets from high to
    // low lets the lowest offset (closest to ptr) win the last assignment.
    always_comb begin
        int j;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) begin
                found = 1'b1;
                pick  = PW'(j);
            end
        end
    end

    assign pick_mod  = req_mod[int'(pick)*CW +: CW];
    // A modulus of 0 or 1 both give a single-cycle sweep ending at count 0.
    assign pick_last = (pick_mod <= CW'(1)) ? '0 : pick_mod - CW'(1);

    assign next_ptr   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    assign win_onehot = NREQ'(1) << win;

    assign wrap      = (state == S_RUN) && (count == last_q) && !hold_eff;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            ptr    <= '0;
            win    <= '0;
            last_q <= '0;
            grant  <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= '0;
            abort  <= 1'b0;
        end else begin
            done  <= '0;
            abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        win    <= pick;
                        last_q <= pick_last;
                        busy   <= 1'b1;
                        count  <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!req[win]) begin
                        abort <= 1'b1;
                        busy  <= 1'b0;
                        ptr   <= next_ptr;
                        state <= S_IDLE;
                    end else begin
                        grant <= win_onehot;
                        count <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!req[win]) begin
                        // Abort wins over hold and over the final count.
                        abort <= 1'b1;
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                        ptr   <= next_ptr;
                        state <= S_IDLE;
                    end else if (!hold_eff) begin
                        if (count == last_q) begin
                            done  <= grant;
                            grant <= '0;
                            busy  <= 1'b0;
                            count <= '0;
                            state <= S_DONE;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    ptr   <= next_ptr;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_counter_arbiter.sv
// tb_mod_counter_arbiter
//   Timeline model: for every sweep the bench derives the winner from the
//   round-robin rule, the sweep length from the latched modulus, and then the
//   expected outputs of each cycle (IDLE, LOAD, RUN..., DONE) directly.
//   Build with +define+MOD_ARB_HOLD_EN to exercise the hold input.
module tb_mod_counter_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 4;

    typedef struct packed {
        logic [NREQ-1:0] grant;
        logic [CW-1:0]   count;
        logic            busy;
        logic            wrap;
        logic [NREQ-1:0] done;
        logic            abort;
    } obs_t;

    localparam int EW = $bits(obs_t);

    logic                 clk;
    logic                 reset;
    logic                 hold;
    logic [NREQ-1:0]      req;
    logic [NREQ*CW-1:0]   req_mod;
    logic [NREQ-1:0]      grant;
    logic [CW-1:0]        count;
    logic                 busy;
    logic                 wrap;
    logic [NREQ-1:0]      done;
    logic                 abort;
    logic [1:0]           state_dbg;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;    // model round-robin pointer
    bit m_abort  = 0;    // model: abort pulse due in the next IDLE cycle

    mod_counter_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MOD_ARB_HOLD_EN
        .hold      (hold),
`endif
        .req       (req),
        .req_mod   (req_mod),
        .grant     (grant),
        .count     (count),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done),
        .abort     (abort),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t mk(input logic [NREQ-1:0] g, input int c, input logic b,
                                input logic w, input logic [NREQ-1:0] d, input logic a);
        obs_t o;
        o.grant = g;
        o.count = CW'(c);
        o.busy  = b;
        o.wrap  = w;
        o.done  = d;
        o.abort = a;
        return o;
    endfunction

    function automatic logic [NREQ*CW-1:0] scr(input bit scramble, input logic [NREQ*CW-1:0] m);
        return scramble ? (NREQ*CW)'($urandom) : m;
    endfunction

    // driver: apply inputs for one cycle, check outputs mid-cycle, advance
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] mv,
                        input logic h, input logic rs, input obs_t e);
        obs_t x;
        req     = r;
        req_mod = mv;
        hold    = h;
        reset   = rs;
        exp_q.push_back(EW'(e));
        @(negedge clk);
        x = obs_t'(exp_q.pop_front());
        check("grant", 32'(grant), 32'(x.grant));
        check("count", 32'(count), 32'(x.count));
        check("busy",  32'(busy),  32'(x.busy));
        check("wrap",  32'(wrap),  32'(x.wrap));
        check("done",  32'(done),  32'(x.done));
        check("abort", 32'(abort), 32'(x.abort));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        step('0, (NREQ*CW)'($urandom), 1'($urandom_range(0, 1)), 1'b0,
             mk('0, 0, 0, 0, '0, m_abort));
        m_abort = 0;
    endtask

    task automatic do_reset();
        step('0, '0, 1'b0, 1'b1, mk('0, 0, 0, 0, '0, m_abort));
        m_ptr   = 0;
        m_abort = 0;
    endtask

    // One arbitration + sweep. abort_at / reset_at / hold_at are count values
    // (-1 = never); the request of the winner drops when count first equals
    // abort_at, reset is applied in the cycle count first equals reset_at.
    task automatic sweep(input logic [NREQ-1:0] rq, input logic [NREQ*CW-1:0] mods,
                         input int abort_at, input int reset_at,
                         input int hold_at, input int hold_len, input bit scramble);
        int w, len, k, hc;
        logic [CW-1:0]   m;
        logic [NREQ-1:0] oh, rcur;
        logic h, rs;
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (m_ptr + i) % NREQ;
            if (w < 0 && rq[j]) w = j;
        end
        if (w < 0) begin
            $display("FAIL bench: empty request vector");
            $fatal(1, "bench");
        end
        m   = mods[w*CW +: CW];
        len = (m <= 1) ? 1 : int'(m);
        oh  = '0;
        oh[w] = 1'b1;
        // IDLE: arbitration and modulus capture
        step(rq, mods, 1'($urandom_range(0, 1)), 1'b0, mk('0, 0, 0, 0, '0, m_abort));
        m_abort = 0;
        // LOAD
        step(rq, scr(scramble, mods), 1'($urandom_range(0, 1)), 1'b0, mk('0, 0, 1, 0, '0, 0));
        // RUN
        rcur = rq;
        k    = 0;
        hc   = 0;
        while (1) begin
`ifdef MOD_ARB_HOLD_EN
            h = (k == hold_at) && (hc < hold_len);
`else
            h = 1'b0;
`endif
            rs = (k == reset_at);
            if (rs) h = 1'b0;
            if (k == abort_at) rcur[w] = 1'b0;
            step(rcur, scr(scramble, mods), h, rs, mk(oh, k, 1, !h && (k == len - 1), '0, 0));
            if (rs) begin
                m_ptr   = 0;
                m_abort = 0;
                return;
            end
            if (!rcur[w]) begin
                m_abort = 1;
                m_ptr   = (w + 1) % NREQ;
                return;
            end
            if (h) hc++;
            else if (k == len - 1) break;
            else k++;
        end
        // DONE
        step(rq, scr(scramble, mods), 1'($urandom_range(0, 1)), 1'b0, mk('0, 0, 0, 0, oh, 0));
        m_ptr = (w + 1) % NREQ;
    endtask

    initial begin
        logic [NREQ-1:0]    rq;
        logic [NREQ*CW-1:0] mods;
        int ab, rsa, ha, hl;
        reset   = 1'b1;
        hold    = 1'b0;
        req     = '0;
        req_mod = '0;
        @(posedge clk);
        #1;
        // reset values
        do_reset();
        idle_cycle();

        // four requesters held, moduli 3,4,5,6: strict rotation
        for (int n = 0; n < 5; n++)
            sweep(4'b1111, {4'd6, 4'd5, 4'd4, 4'd3}, -1, -1, -1, 0, 0);
        idle_cycle();

        // single requester, modulus 9
        sweep(4'b0001, {4'd0, 4'd0, 4'd0, 4'd9}, -1, -1, -1, 0, 0);
        idle_cycle();
        idle_cycle();

        // moduli 0 and 1, req_mod scrambled after capture
        sweep(4'b0001, {4'd7, 4'd7, 4'd7, 4'd0}, -1, -1, -1, 0, 1);
        idle_cycle();
        sweep(4'b0001, {4'd7, 4'd7, 4'd7, 4'd1}, -1, -1, -1, 0, 1);
        idle_cycle();
        // full-length sweep with scrambled req_mod
        sweep(4'b0001, {4'd0, 4'd0, 4'd0, 4'd15}, -1, -1, -1, 0, 1);
        idle_cycle();

        // reset at count 5, then 1010 must go to requester 1
        sweep(4'b0001, {4'd0, 4'd0, 4'd0, 4'd9}, -1, 5, -1, 0, 0);
        sweep(4'b1010, {4'd2, 4'd0, 4'd3, 4'd0}, -1, -1, -1, 0, 0);
        idle_cycle();

        // abort at count 4 with requester 1 pending
        do_reset();
        sweep(4'b0011, {4'd0, 4'd0, 4'd4, 4'd9}, 4, -1, -1, 0, 0);
        sweep(4'b0010, {4'd0, 4'd0, 4'd4, 4'd9}, -1, -1, -1, 0, 0);
        idle_cycle();

`ifdef MOD_ARB_HOLD_EN
        // hold for 3 cycles at count 2 with modulus 5
        sweep(4'b0001, {4'd0, 4'd0, 4'd0, 4'd5}, -1, -1, 2, 3, 0);
        idle_cycle();
`endif

        // randomized sweeps
        for (int n = 0; n < 60; n++) begin
            rq   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            mods = (NREQ*CW)'($urandom);
            ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
            rsa  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 15)) : -1;
            ha   = int'($urandom_range(0, 15));
            hl   = int'($urandom_range(0, 3));
            sweep(rq, mods, ab, rsa, ha, hl, 1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
